pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard bus between the pipeline datapath and the hazard sequencer:
// hazard sources flow in, per-stage enable/flush and PC control flow out.
interface pipeline_hazard_ctrl_if;
  logic       if_valid;
  logic       dc_busy;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_serialize;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       memwb_bubble;
  logic       br_taken;

  logic       pc_en;
  logic       pc_redirect;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       exmem_flush;
  logic       memwb_en;
  logic       memwb_flush;

  modport master (
    output if_valid, dc_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_serialize,
           ex_is_load, ex_rd, idex_bubble, exmem_bubble, memwb_bubble, br_taken,
    input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush
  );

  modport slave (
    input  if_valid, dc_busy, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_serialize,
           ex_is_load, ex_rd, idex_bubble, exmem_bubble, memwb_bubble, br_taken,
    output pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: per-stage enable/flush, PC hold and
// redirect, plus saturating stall/flush performance counters.
module phc_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int BOOT_HOLD = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [1:0]           ctrl_state,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  // Stage index: 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
  localparam int NUM_STG = 4;
  localparam int BW      = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;

  state_t             state, nxt;
  logic [BW-1:0]      boot_cnt;
  logic               boot_last;
  logic               load_use, drain;
  logic               pc_en, pc_redirect;
  logic [NUM_STG-1:0] stg_en, stg_flush;
  logic [1:0]         cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_q;

  assign boot_last = (int'(boot_cnt) >= BOOT_HOLD - 1);

  assign load_use = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
                    ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                     (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
  // Serializing op waits in ID until everything downstream has drained
  assign drain    = hz.id_serialize &&
                    !(hz.idex_bubble && hz.exmem_bubble && hz.memwb_bubble);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == BOOT && !boot_last) boot_cnt <= boot_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt         = state;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    stg_en      = '1;
    stg_flush   = '0;
    case (state)
      BOOT: begin
        stg_flush = '1;
        if (boot_last) nxt = RUN;
      end
      REDIRECT: begin
        if (hz.dc_busy) begin
          stg_en = '0;
          nxt    = MEM_WAIT;
        end else begin
          stg_flush[0] = 1'b1;
          pc_en        = hz.if_valid;
          nxt          = RUN;
        end
      end
      default: begin
        // RUN and the release cycle of MEM_WAIT share one priority chain
        if (hz.dc_busy) begin
          stg_en = '0;
          nxt    = MEM_WAIT;
        end else if (hz.br_taken) begin
          pc_en          = 1'b1;
          pc_redirect    = 1'b1;
          stg_flush[2:0] = '1;
          nxt            = REDIRECT;
        end else if (load_use || drain) begin
          stg_en[0]    = 1'b0;
          stg_flush[1] = 1'b1;
          nxt          = RUN;
        end else if (!hz.if_valid) begin
          stg_flush[0] = 1'b1;
          nxt          = RUN;
        end else begin
          pc_en = 1'b1;
          nxt   = RUN;
        end
      end
    endcase
  end

  assign hz.pc_en       = pc_en;
  assign hz.pc_redirect = pc_redirect;
  assign hz.ifid_en     = stg_en[0];
  assign hz.ifid_flush  = stg_flush[0];
  assign hz.idex_en     = stg_en[1];
  assign hz.idex_flush  = stg_flush[1];
  assign hz.exmem_en    = stg_en[2];
  assign hz.exmem_flush = stg_flush[2];
  assign hz.memwb_en    = stg_en[3];
  assign hz.memwb_flush = stg_flush[3];
  assign ctrl_state     = state;

  assign cnt_inc[0] = (state != BOOT) && !pc_en;
  assign cnt_inc[1] = (nxt == REDIRECT) && (state != REDIRECT);

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    phc_sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[g]),
      .cnt   (cnt_q[g])
    );
  end

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random stimulus for pipeline_hazard_ctrl against a rule-level
// reference model of the stall/flush priorities and counters.
module tb_pipeline_hazard_ctrl;
  localparam int BOOT_HOLD = 2;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic pc_en, pc_redirect;
    logic ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush;
  } ctl_t;

  localparam int A_BOOT = 0, A_FREEZE = 1, A_BRANCH = 2, A_HOLDID = 3,
                 A_BUBIF = 4, A_GO = 5, A_POSTRED = 6;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  ctl_t             dut_ctl;

  int vectors = 0, miscompares = 0;
  int m_state, m_boot, m_stall, m_flush;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.BOOT_HOLD(BOOT_HOLD), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hz),
    .ctrl_state (ctrl_state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  assign dut_ctl = '{hz.pc_en, hz.pc_redirect, hz.ifid_en, hz.ifid_flush, hz.idex_en,
                     hz.idex_flush, hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which rule governs this cycle, from the documented priority list
  function automatic int decide();
    logic hit1, hit2;
    if (m_state == 0) return A_BOOT;
    if (hz.dc_busy)   return A_FREEZE;
    if (m_state == 3) return A_POSTRED;
    if (hz.br_taken)  return A_BRANCH;
    hit1 = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    hit2 = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    if (hz.ex_is_load && hz.ex_rd != 0 && (hit1 || hit2)) return A_HOLDID;
    if (hz.id_serialize && !(hz.idex_bubble && hz.exmem_bubble && hz.memwb_bubble)) return A_HOLDID;
    if (!hz.if_valid) return A_BUBIF;
    return A_GO;
  endfunction

  function automatic ctl_t pattern(input int act);
    ctl_t c;
    c = '{pc_en:1'b0, pc_redirect:1'b0, ifid_en:1'b1, ifid_flush:1'b0, idex_en:1'b1,
          idex_flush:1'b0, exmem_en:1'b1, exmem_flush:1'b0, memwb_en:1'b1, memwb_flush:1'b0};
    case (act)
      A_BOOT:    begin c.ifid_flush = 1; c.idex_flush = 1; c.exmem_flush = 1; c.memwb_flush = 1; end
      A_FREEZE:  begin c.ifid_en = 0; c.idex_en = 0; c.exmem_en = 0; c.memwb_en = 0; end
      A_BRANCH:  begin c.pc_en = 1; c.pc_redirect = 1; c.ifid_flush = 1; c.idex_flush = 1; c.exmem_flush = 1; end
      A_HOLDID:  begin c.ifid_en = 0; c.idex_flush = 1; end
      A_BUBIF:   c.ifid_flush = 1;
      A_POSTRED: begin c.ifid_flush = 1; c.pc_en = hz.if_valid; end
      default:   c.pc_en = 1;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0; m_boot = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic advance(input int act, input ctl_t e);
    if (m_state != 0 && !e.pc_en && m_stall < (1 << CNT_W) - 1) m_stall++;
    case (act)
      A_BOOT:   if (m_boot + 1 >= BOOT_HOLD) m_state = 1; else m_boot++;
      A_FREEZE: m_state = 2;
      A_BRANCH: begin
        m_state = 3;
        if (m_flush < (1 << CNT_W) - 1) m_flush++;
      end
      default:  m_state = 1;
    endcase
  endtask

  // Caller sets inputs just after a rising edge; outputs compared at the falling edge
  task automatic step();
    int   act;
    ctl_t e;
    act = decide();
    e   = pattern(act);
    @(negedge clk);
    chk("ctl",   32'(dut_ctl),   32'(e));
    chk("state", 32'(ctrl_state), 32'(m_state));
    chk("stall", 32'(stall_cnt),  32'(m_stall));
    chk("flush", 32'(flush_cnt),  32'(m_flush));
    @(posedge clk);
    advance(act, e);
    #1;
  endtask

  task automatic idle_inputs();
    hz.if_valid = 1; hz.dc_busy = 0; hz.id_rs1 = 0; hz.id_rs2 = 0;
    hz.id_use_rs1 = 0; hz.id_use_rs2 = 0; hz.id_serialize = 0;
    hz.ex_is_load = 0; hz.ex_rd = 0; hz.idex_bubble = 1; hz.exmem_bubble = 1;
    hz.memwb_bubble = 1; hz.br_taken = 0;
  endtask

  task automatic rand_inputs();
    hz.if_valid     = ($urandom_range(0, 4) != 0);
    hz.dc_busy      = ($urandom_range(0, 5) == 0);
    hz.br_taken     = ($urandom_range(0, 7) == 0);
    hz.id_rs1       = 5'($urandom_range(0, 3));
    hz.id_rs2       = 5'($urandom_range(0, 3));
    hz.ex_rd        = 5'($urandom_range(0, 3));
    hz.id_use_rs1   = 1'($urandom);
    hz.id_use_rs2   = 1'($urandom);
    hz.ex_is_load   = 1'($urandom);
    hz.id_serialize = ($urandom_range(0, 5) == 0);
    hz.idex_bubble  = 1'($urandom);
    hz.exmem_bubble = 1'($urandom);
    hz.memwb_bubble = 1'($urandom);
  endtask

  initial begin
    int s0, f0;
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",   32'(dut_ctl), 32'(pattern(A_BOOT)));
    chk("rst_state", 32'(ctrl_state), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    reset = 0;

    // Boot hold, then free-running
    repeat (BOOT_HOLD) step();
    step();
    chk("boot_run", 32'(ctrl_state), 1);

    // Load-use on rs2, then cleared
    hz.ex_is_load = 1; hz.ex_rd = 5; hz.id_rs2 = 5; hz.id_use_rs2 = 1;
    step();
    hz.ex_is_load = 0;
    step();
    // Same with x0 destination: no stall
    hz.ex_is_load = 1; hz.ex_rd = 0; hz.id_rs2 = 0;
    step();
    idle_inputs();

    // Taken branch, then the redirect cycle
    f0 = int'(flush_cnt);
    hz.br_taken = 1;
    step();
    hz.br_taken = 0;
    step();
    chk("br_flush_delta", 32'(int'(flush_cnt) - f0), 1);
    step();

    // Cache stall held across a pending branch
    s0 = int'(stall_cnt);
    f0 = int'(flush_cnt);
    hz.br_taken = 1; hz.dc_busy = 1;
    repeat (3) step();
    chk("dc_stall_delta", 32'(int'(stall_cnt) - s0), 3);
    hz.dc_busy = 0;
    step();
    hz.br_taken = 0;
    step();
    step();
    chk("dc_flush_delta", 32'(int'(flush_cnt) - f0), 1);

    // Serialize waits for drain
    hz.id_serialize = 1; hz.exmem_bubble = 0;
    repeat (2) step();
    hz.exmem_bubble = 1;
    step();
    idle_inputs();

    // Redirect cycle hit by a cache stall, and a fetch miss after redirect
    hz.br_taken = 1; step();
    hz.br_taken = 0; hz.dc_busy = 1; step();
    hz.dc_busy = 0; step();
    hz.br_taken = 1; step();
    hz.br_taken = 0; hz.if_valid = 0; step();
    idle_inputs();

    // Random traffic with a mid-run reset; 4-bit counters exercise saturation
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        reset = 1;
        #1;
        chk("midrst_state", 32'(ctrl_state), 0);
        chk("midrst_stall", 32'(stall_cnt), 0);
        chk("midrst_flush", 32'(flush_cnt), 0);
        chk("midrst_ctl",   32'(dut_ctl), 32'(pattern(A_BOOT)));
        reset = 0;
        model_reset();
      end
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
